// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared types for the multicycle controller with memory
//                wait-states: FSM state enum, opcode constants, a decoded
//                opcode enum with its decode function, and the control-word
//                struct that bundles every datapath strobe.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_DEC   = 4'd1,
        S_LDI   = 4'd2,
        S_MVR   = 4'd3,
        S_RT    = 4'd4,
        S_WB_R  = 4'd5,
        S_IF2   = 4'd6,
        S_JMP   = 4'd7,
        S_STA   = 4'd8,
        S_LDM   = 4'd9,
        S_LDA   = 4'd10,
        S_ALUM  = 4'd11,
        S_WB_M  = 4'd12,
        S_FAULT = 4'd13
    } state_t;

    // Full 4-bit opcodes (checked first)
    localparam logic [3:0] c_OP_MVR = 4'b1100;
    localparam logic [3:0] c_OP_ADR = 4'b1101;
    localparam logic [3:0] c_OP_ANR = 4'b1110;
    localparam logic [3:0] c_OP_ORR = 4'b1111;
    // 3-bit opcodes on instruction[3:1]
    localparam logic [2:0] c_OP_LDI = 3'b000;
    localparam logic [2:0] c_OP_LDA = 3'b001;
    localparam logic [2:0] c_OP_STA = 3'b010;
    localparam logic [2:0] c_OP_ADA = 3'b011;
    localparam logic [2:0] c_OP_ANA = 3'b100;
    localparam logic [2:0] c_OP_JMP = 3'b101;

    typedef enum logic [3:0] {
        OP_LDI, OP_LDA, OP_STA, OP_ADA, OP_ANA, OP_JMP,
        OP_MVR, OP_ADR, OP_ANR, OP_ORR, OP_BAD
    } op_t;

    // Full 4-bit encodings take priority over the 3-bit ones.
    function automatic op_t decode_op(input logic [3:0] instr);
        op_t op;
        op = OP_BAD;
        if      (instr == c_OP_MVR) op = OP_MVR;
        else if (instr == c_OP_ADR) op = OP_ADR;
        else if (instr == c_OP_ANR) op = OP_ANR;
        else if (instr == c_OP_ORR) op = OP_ORR;
        else begin
            case (instr[3:1])
                c_OP_LDI: op = OP_LDI;
                c_OP_LDA: op = OP_LDA;
                c_OP_STA: op = OP_STA;
                c_OP_ADA: op = OP_ADA;
                c_OP_ANA: op = OP_ANA;
                c_OP_JMP: op = OP_JMP;
                default:  op = OP_BAD;
            endcase
        end
        return op;
    endfunction

    typedef struct packed {
        logic mem_req;
        logic mem_read;
        logic mem_write;
        logic bus_fault;
        logic instr_done;
        logic ld_pc;
        logic ld_ir;
        logic ld_di;
        logic ld_alu;
        logic ld_tr;
        logic ld_czn;
        logic write_en_rf;
        logic sel_ir_3_2;
        logic sel_di_4_3;
        logic sel_mem_src_pc;
        logic sel_mem_src_tr;
        logic sel_alu_src_reg1;
        logic sel_alu_src_tr;
        logic sel_czn_src_rf;
        logic sel_czn_src_alu;
        logic sel_pc_src_jump;
        logic sel_rf_write_src_alu;
        logic sel_rf_write_src_reg1;
        logic sel_rf_write_src_tr_12_5;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_ws_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_ws_if
//  Description : Memory handshake bundle between the controller and memory.
//                mem_req/MEM_read/MEM_write come from the controller,
//                mem_ready comes back from memory.
//  Ports       : master = controller side, slave = memory side
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_ctrl_ws_if;
    logic mem_req;
    logic mem_ready;
    logic MEM_read;
    logic MEM_write;

    modport master (output mem_req, output MEM_read, output MEM_write,
                    input  mem_ready);
    modport slave  (input  mem_req, input  MEM_read, input  MEM_write,
                    output mem_ready);
endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_timer
//  Description : Counts memory wait cycles for the current access and flags
//                the cycle in which the access has run out of budget.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                start      - clear the counter (FSM is changing state)
//                mem_ready  - memory completes this cycle
//                expired    - last permitted wait cycle with mem_ready low
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic start,
    input  wire logic mem_ready,
    output logic      expired
);
    // A zero timeout still needs a legal 1-bit counter.
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Saturating count of wait cycles; never wraps back to a small value.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_cnt <= '0;
        end else if (!mem_ready && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(MEM_TIMEOUT - 1);
            // mem_ready in the same cycle always beats the timeout.
            assign expired = !mem_ready && (r_cnt == c_LIMIT);
        end else begin : g_no_timeout
            logic w_unused_cnt;
            assign w_unused_cnt = ^r_cnt;
            assign expired      = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_ws
//  Description : Multicycle CPU control unit with memory wait-states.
//                Sequences fetch/decode/execute/writeback, waits on a
//                req/ready memory handshake and traps into a sticky FAULT
//                state when an access exceeds MEM_TIMEOUT cycles.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                instruction[3:0]    - IR opcode bits
//                out_jump_sel        - jump condition from flag logic
//                bus                 - memory handshake (master modport)
//                bus_fault           - sticky fault flag
//                instr_done          - pulse in an instruction's last cycle
//                ld_* / write_en_rf  - register load/write enables
//                sel_*               - datapath mux selects
//                cen_PC              - tied low
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_ws
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [3:0] instruction,
    input  wire logic       out_jump_sel,
    mc_ctrl_ws_if.master    bus,
    output logic            bus_fault,
    output logic            instr_done,
    output logic            ld_PC,
    output logic            ld_IR,
    output logic            ld_DI,
    output logic            ld_ALU,
    output logic            ld_TR,
    output logic            ld_CZN,
    output logic            write_en_rf,
    output logic            sel_IR_3_2,
    output logic            sel_DI_4_3,
    output logic            sel_MEM_src_PC,
    output logic            sel_MEM_src_TR,
    output logic            sel_ALU_src_reg1,
    output logic            sel_ALU_src_TR,
    output logic            sel_CZN_src_RF,
    output logic            sel_CZN_src_ALU,
    output logic            sel_PC_src_jump,
    output logic            sel_RF_write_src_ALU,
    output logic            sel_RF_write_src_reg1,
    output logic            sel_RF_write_src_TR_12_5,
    output logic            cen_PC
);

    state_t r_state;
    state_t w_state_next;
    op_t    w_op;
    logic   w_expired;
    logic   w_ready;
    ctrl_t  w_cw;

    assign w_op    = decode_op(instruction);
    assign w_ready = bus.mem_ready;

    // Any state change clears the wait counter, so every memory state
    // starts its access with a fresh budget.
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (w_state_next != r_state),
        .mem_ready (w_ready),
        .expired   (w_expired)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IF: begin
                if (w_ready)        w_state_next = S_DEC;
                else if (w_expired) w_state_next = S_FAULT;
            end
            S_DEC: begin
                case (w_op)
                    OP_LDI:                 w_state_next = S_LDI;
                    OP_MVR:                 w_state_next = S_MVR;
                    OP_ADR, OP_ANR, OP_ORR: w_state_next = S_RT;
                    default:                w_state_next = S_IF2;
                endcase
            end
            S_RT:   w_state_next = S_WB_R;
            S_IF2: begin
                if (w_ready) begin
                    case (w_op)
                        OP_JMP:  w_state_next = S_JMP;
                        OP_STA:  w_state_next = S_STA;
                        default: w_state_next = S_LDM;
                    endcase
                end else if (w_expired) begin
                    w_state_next = S_FAULT;
                end
            end
            S_STA: begin
                if (w_ready)        w_state_next = S_IF;
                else if (w_expired) w_state_next = S_FAULT;
            end
            S_LDM: begin
                if (w_ready)        w_state_next = (w_op == OP_LDA) ? S_LDA : S_ALUM;
                else if (w_expired) w_state_next = S_FAULT;
            end
            S_ALUM: w_state_next = S_WB_M;
            S_LDI, S_MVR, S_WB_R, S_JMP, S_LDA, S_WB_M: w_state_next = S_IF;
            S_FAULT: w_state_next = S_FAULT;
            default: w_state_next = S_IF;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_cw = '0;
        case (r_state)
            S_IF: begin
                w_cw.mem_req        = 1'b1;
                w_cw.mem_read       = 1'b1;
                w_cw.sel_mem_src_pc = 1'b1;
                w_cw.ld_ir          = w_ready;
                w_cw.ld_pc          = w_ready;
            end
            S_LDI: begin
                w_cw.ld_di      = 1'b1;
                w_cw.instr_done = 1'b1;
            end
            S_MVR: begin
                w_cw.sel_rf_write_src_reg1 = 1'b1;
                w_cw.sel_ir_3_2            = 1'b1;
                w_cw.write_en_rf           = 1'b1;
                w_cw.instr_done            = 1'b1;
            end
            S_RT: begin
                w_cw.sel_ir_3_2       = 1'b1;
                w_cw.sel_alu_src_reg1 = 1'b1;
                w_cw.ld_alu           = 1'b1;
                w_cw.ld_czn           = 1'b1;
                w_cw.sel_czn_src_alu  = 1'b1;
            end
            S_WB_R: begin
                w_cw.sel_rf_write_src_alu = 1'b1;
                w_cw.write_en_rf          = 1'b1;
                w_cw.instr_done           = 1'b1;
            end
            S_IF2: begin
                w_cw.mem_req        = 1'b1;
                w_cw.mem_read       = 1'b1;
                w_cw.sel_mem_src_pc = 1'b1;
                w_cw.ld_tr          = w_ready;
                w_cw.ld_pc          = w_ready;
            end
            S_JMP: begin
                w_cw.ld_pc           = out_jump_sel;
                w_cw.sel_pc_src_jump = out_jump_sel;
                w_cw.instr_done      = 1'b1;
            end
            S_STA: begin
                w_cw.mem_req        = 1'b1;
                w_cw.mem_write      = 1'b1;
                w_cw.sel_mem_src_tr = 1'b1;
                w_cw.sel_di_4_3     = 1'b1;
                w_cw.instr_done     = w_ready;
            end
            S_LDM: begin
                w_cw.mem_req        = 1'b1;
                w_cw.mem_read       = 1'b1;
                w_cw.sel_mem_src_tr = 1'b1;
                w_cw.ld_tr          = w_ready;
            end
            S_LDA: begin
                w_cw.sel_di_4_3               = 1'b1;
                w_cw.sel_rf_write_src_tr_12_5 = 1'b1;
                w_cw.write_en_rf              = 1'b1;
                w_cw.ld_czn                   = 1'b1;
                w_cw.sel_czn_src_rf           = 1'b1;
                w_cw.instr_done               = 1'b1;
            end
            S_ALUM: begin
                w_cw.sel_di_4_3      = 1'b1;
                w_cw.sel_alu_src_tr  = 1'b1;
                w_cw.ld_alu          = 1'b1;
                w_cw.ld_czn          = 1'b1;
                w_cw.sel_czn_src_alu = 1'b1;
            end
            S_WB_M: begin
                w_cw.sel_rf_write_src_alu = 1'b1;
                w_cw.write_en_rf          = 1'b1;
                w_cw.instr_done           = 1'b1;
                w_cw.sel_di_4_3           = 1'b1;
            end
            S_FAULT: begin
                w_cw.bus_fault = 1'b1;
            end
            default: w_cw = '0;
        endcase

        // Reset aborts immediately: nothing may be loaded or written in a
        // reset cycle, whatever state the FSM happens to be in.
        if (rst) begin
            w_cw.ld_pc       = 1'b0;
            w_cw.ld_ir       = 1'b0;
            w_cw.ld_di       = 1'b0;
            w_cw.ld_alu      = 1'b0;
            w_cw.ld_tr       = 1'b0;
            w_cw.ld_czn      = 1'b0;
            w_cw.write_en_rf = 1'b0;
            w_cw.mem_write   = 1'b0;
            w_cw.instr_done  = 1'b0;
        end
    end

    assign bus.mem_req               = w_cw.mem_req;
    assign bus.MEM_read              = w_cw.mem_read;
    assign bus.MEM_write             = w_cw.mem_write;
    assign bus_fault                 = w_cw.bus_fault;
    assign instr_done                = w_cw.instr_done;
    assign ld_PC                     = w_cw.ld_pc;
    assign ld_IR                     = w_cw.ld_ir;
    assign ld_DI                     = w_cw.ld_di;
    assign ld_ALU                    = w_cw.ld_alu;
    assign ld_TR                     = w_cw.ld_tr;
    assign ld_CZN                    = w_cw.ld_czn;
    assign write_en_rf               = w_cw.write_en_rf;
    assign sel_IR_3_2                = w_cw.sel_ir_3_2;
    assign sel_DI_4_3                = w_cw.sel_di_4_3;
    assign sel_MEM_src_PC            = w_cw.sel_mem_src_pc;
    assign sel_MEM_src_TR            = w_cw.sel_mem_src_tr;
    assign sel_ALU_src_reg1          = w_cw.sel_alu_src_reg1;
    assign sel_ALU_src_TR            = w_cw.sel_alu_src_tr;
    assign sel_CZN_src_RF            = w_cw.sel_czn_src_rf;
    assign sel_CZN_src_ALU           = w_cw.sel_czn_src_alu;
    assign sel_PC_src_jump           = w_cw.sel_pc_src_jump;
    assign sel_RF_write_src_ALU      = w_cw.sel_rf_write_src_alu;
    assign sel_RF_write_src_reg1     = w_cw.sel_rf_write_src_reg1;
    assign sel_RF_write_src_TR_12_5  = w_cw.sel_rf_write_src_tr_12_5;
    assign cen_PC                    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl_ws
//  Description : Self-checking bench for mc_ctrl_ws (MEM_TIMEOUT = 4).
//                Each instruction is expanded into its list of phases, with
//                memory phases repeated once per wait cycle; the expected
//                strobe word of each cycle follows from the phase alone.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_ws;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] instruction;
    logic       out_jump_sel;
    logic bus_fault, instr_done, ld_PC, ld_IR, ld_DI, ld_ALU, ld_TR, ld_CZN;
    logic write_en_rf, sel_IR_3_2, sel_DI_4_3, sel_MEM_src_PC, sel_MEM_src_TR;
    logic sel_ALU_src_reg1, sel_ALU_src_TR, sel_CZN_src_RF, sel_CZN_src_ALU;
    logic sel_PC_src_jump, sel_RF_write_src_ALU, sel_RF_write_src_reg1;
    logic sel_RF_write_src_TR_12_5, cen_PC;

    mc_ctrl_ws_if bus_if ();

    mc_ctrl_ws #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .out_jump_sel(out_jump_sel), .bus(bus_if),
        .bus_fault(bus_fault), .instr_done(instr_done),
        .ld_PC(ld_PC), .ld_IR(ld_IR), .ld_DI(ld_DI), .ld_ALU(ld_ALU),
        .ld_TR(ld_TR), .ld_CZN(ld_CZN), .write_en_rf(write_en_rf),
        .sel_IR_3_2(sel_IR_3_2), .sel_DI_4_3(sel_DI_4_3),
        .sel_MEM_src_PC(sel_MEM_src_PC), .sel_MEM_src_TR(sel_MEM_src_TR),
        .sel_ALU_src_reg1(sel_ALU_src_reg1), .sel_ALU_src_TR(sel_ALU_src_TR),
        .sel_CZN_src_RF(sel_CZN_src_RF), .sel_CZN_src_ALU(sel_CZN_src_ALU),
        .sel_PC_src_jump(sel_PC_src_jump),
        .sel_RF_write_src_ALU(sel_RF_write_src_ALU),
        .sel_RF_write_src_reg1(sel_RF_write_src_reg1),
        .sel_RF_write_src_TR_12_5(sel_RF_write_src_TR_12_5),
        .cen_PC(cen_PC)
    );

    always #5 clk = ~clk;

    // Observed strobe word, bit 0 = mem_req ... bit 24 = cen_PC
    logic [24:0] act;
    assign act = {cen_PC, bus_if.MEM_write, bus_if.MEM_read,
                  sel_RF_write_src_TR_12_5, sel_RF_write_src_reg1,
                  sel_RF_write_src_ALU, sel_PC_src_jump, sel_CZN_src_ALU,
                  sel_CZN_src_RF, sel_ALU_src_TR, sel_ALU_src_reg1,
                  sel_MEM_src_TR, sel_MEM_src_PC, sel_DI_4_3, sel_IR_3_2,
                  write_en_rf, ld_CZN, ld_TR, ld_ALU, ld_DI, ld_IR, ld_PC,
                  instr_done, bus_fault, bus_if.mem_req};

    localparam logic [24:0] M_REQ = 25'h1 << 0,  M_FLT = 25'h1 << 1;
    localparam logic [24:0] M_DONE = 25'h1 << 2, M_LDPC = 25'h1 << 3;
    localparam logic [24:0] M_LDIR = 25'h1 << 4, M_LDDI = 25'h1 << 5;
    localparam logic [24:0] M_LDALU = 25'h1 << 6, M_LDTR = 25'h1 << 7;
    localparam logic [24:0] M_LDCZN = 25'h1 << 8, M_WE = 25'h1 << 9;
    localparam logic [24:0] M_IR32 = 25'h1 << 10, M_DI43 = 25'h1 << 11;
    localparam logic [24:0] M_MPC = 25'h1 << 12, M_MTR = 25'h1 << 13;
    localparam logic [24:0] M_AREG = 25'h1 << 14, M_ATR = 25'h1 << 15;
    localparam logic [24:0] M_CRF = 25'h1 << 16, M_CALU = 25'h1 << 17;
    localparam logic [24:0] M_PCJ = 25'h1 << 18, M_RFALU = 25'h1 << 19;
    localparam logic [24:0] M_RFREG = 25'h1 << 20, M_RFTR = 25'h1 << 21;
    localparam logic [24:0] M_RD = 25'h1 << 22, M_WR = 25'h1 << 23;

    // Instruction phases
    localparam int P_FETCH = 0, P_DECODE = 1, P_LDI = 2, P_MOVE = 3;
    localparam int P_REGOP = 4, P_REGWB = 5, P_OPFETCH = 6, P_JUMP = 7;
    localparam int P_STORE = 8, P_MEMRD = 9, P_LOAD = 10, P_MEMOP = 11;
    localparam int P_MEMWB = 12, P_TRAP = 13;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [24:0] exp_word(int ph, bit rdy, bit jmp, bit in_rst);
        logic [24:0] w;
        w = '0;
        case (ph)
            P_FETCH:   w = M_REQ | M_RD | M_MPC | (rdy ? (M_LDIR | M_LDPC) : 25'h0);
            P_OPFETCH: w = M_REQ | M_RD | M_MPC | (rdy ? (M_LDTR | M_LDPC) : 25'h0);
            P_DECODE:  w = '0;
            P_LDI:     w = M_LDDI | M_DONE;
            P_MOVE:    w = M_RFREG | M_IR32 | M_WE | M_DONE;
            P_REGOP:   w = M_IR32 | M_AREG | M_LDALU | M_LDCZN | M_CALU;
            P_REGWB:   w = M_RFALU | M_WE | M_DONE;
            P_JUMP:    w = M_DONE | (jmp ? (M_LDPC | M_PCJ) : 25'h0);
            P_STORE:   w = M_REQ | M_WR | M_MTR | M_DI43 | (rdy ? M_DONE : 25'h0);
            P_MEMRD:   w = M_REQ | M_RD | M_MTR | (rdy ? M_LDTR : 25'h0);
            P_LOAD:    w = M_DI43 | M_RFTR | M_WE | M_LDCZN | M_CRF | M_DONE;
            P_MEMOP:   w = M_DI43 | M_ATR | M_LDALU | M_LDCZN | M_CALU;
            P_MEMWB:   w = M_RFALU | M_WE | M_DONE | M_DI43;
            P_TRAP:    w = M_FLT;
            default:   w = '0;
        endcase
        if (in_rst)
            w &= ~(M_LDPC | M_LDIR | M_LDDI | M_LDALU | M_LDTR | M_LDCZN |
                   M_WE | M_WR | M_DONE);
        return w;
    endfunction

    // One clock cycle: drive, compare at the falling edge, advance.
    task automatic step(input int ph, input bit rdy, input bit jmp,
                        input bit r, input string name, output bit done);
        logic [24:0] e;
        rst              = r;
        bus_if.mem_ready = rdy;
        out_jump_sel     = jmp;
        @(negedge clk);
        e = exp_word(ph, rdy, jmp, r);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: phase %0d got %h want %h", name, ph, act, e);
        end
        done = act[2];
        @(posedge clk);
        #1;
    endtask

    // Run a whole instruction; w0/w1/w2 = wait cycles for the fetch,
    // operand fetch and data access. lat = cycle of the observed done pulse.
    task automatic run_instr(input logic [3:0] ins, input bit jmp,
                             input int w0, input int w1, input int w2,
                             input string name, output int lat);
        int q_ph[$];
        bit q_rdy[$];
        logic [2:0] hi;
        bit d;
        hi = ins[3:1];
        instruction = ins;
        for (int i = 0; i < w0; i++) begin q_ph.push_back(P_FETCH); q_rdy.push_back(1'b0); end
        q_ph.push_back(P_FETCH);  q_rdy.push_back(1'b1);
        q_ph.push_back(P_DECODE); q_rdy.push_back(1'b1);
        if (ins == 4'b1100) begin
            q_ph.push_back(P_MOVE); q_rdy.push_back(1'b1);
        end else if (ins >= 4'b1101) begin
            q_ph.push_back(P_REGOP); q_rdy.push_back(1'b1);
            q_ph.push_back(P_REGWB); q_rdy.push_back(1'b1);
        end else if (hi == 3'b000) begin
            q_ph.push_back(P_LDI); q_rdy.push_back(1'b1);
        end else begin
            for (int i = 0; i < w1; i++) begin q_ph.push_back(P_OPFETCH); q_rdy.push_back(1'b0); end
            q_ph.push_back(P_OPFETCH); q_rdy.push_back(1'b1);
            if (hi == 3'b101) begin
                q_ph.push_back(P_JUMP); q_rdy.push_back(1'b1);
            end else if (hi == 3'b010) begin
                for (int i = 0; i < w2; i++) begin q_ph.push_back(P_STORE); q_rdy.push_back(1'b0); end
                q_ph.push_back(P_STORE); q_rdy.push_back(1'b1);
            end else begin
                for (int i = 0; i < w2; i++) begin q_ph.push_back(P_MEMRD); q_rdy.push_back(1'b0); end
                q_ph.push_back(P_MEMRD); q_rdy.push_back(1'b1);
                if (hi == 3'b001) begin
                    q_ph.push_back(P_LOAD); q_rdy.push_back(1'b1);
                end else begin
                    q_ph.push_back(P_MEMOP); q_rdy.push_back(1'b1);
                    q_ph.push_back(P_MEMWB); q_rdy.push_back(1'b1);
                end
            end
        end
        lat = -1;
        foreach (q_ph[i]) begin
            step(q_ph[i], q_rdy[i], jmp, 1'b0, name, d);
            if (d && lat < 0) lat = i + 1;
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    typedef struct {
        logic [3:0] instr;
        bit         jmp;
        int         lat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int lat;
        bit d;
        tbl[0]  = '{4'b1101, 1'b0, 4};   // ADR
        tbl[1]  = '{4'b1110, 1'b0, 4};   // ANR
        tbl[2]  = '{4'b1111, 1'b1, 4};   // ORR
        tbl[3]  = '{4'b1100, 1'b0, 3};   // MVR
        tbl[4]  = '{4'b0001, 1'b0, 3};   // LDI
        tbl[5]  = '{4'b1010, 1'b0, 4};   // JMP not taken
        tbl[6]  = '{4'b1011, 1'b1, 4};   // JMP taken
        tbl[7]  = '{4'b0100, 1'b0, 4};   // STA
        tbl[8]  = '{4'b0011, 1'b0, 5};   // LDA
        tbl[9]  = '{4'b0110, 1'b0, 6};   // ADA
        tbl[10] = '{4'b1001, 1'b0, 6};   // ANA
        tbl[11] = '{4'b0000, 1'b1, 3};   // LDI

        rst = 1'b1;
        instruction = 4'b0000;
        out_jump_sel = 1'b0;
        bus_if.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Held in reset with mem_ready high: IF strobes, no loads.
        step(P_FETCH, 1'b1, 1'b0, 1'b1, "reset_if", d);
        step(P_FETCH, 1'b1, 1'b0, 1'b1, "reset_if2", d);

        foreach (tbl[i]) begin
            run_instr(tbl[i].instr, tbl[i].jmp, 0, 0, 0, $sformatf("vec%0d", i), lat);
            chk_int($sformatf("latency_vec%0d", i), lat, tbl[i].lat);
        end

        // Fetch waits three cycles, then completes
        run_instr(4'b1101, 1'b0, 3, 0, 0, "if_wait3", lat);
        chk_int("latency_if_wait3", lat, 7);

        // Store completes on the last permitted wait cycle
        run_instr(4'b0100, 1'b0, 0, 0, TO - 1, "sta_edge", lat);
        chk_int("latency_sta_edge", lat, 4 + TO - 1);

        // Store times out, traps into FAULT, stays there until reset
        instruction = 4'b0100;
        step(P_FETCH, 1'b1, 1'b0, 1'b0, "to_if", d);
        step(P_DECODE, 1'b1, 1'b0, 1'b0, "to_dec", d);
        step(P_OPFETCH, 1'b1, 1'b0, 1'b0, "to_if2", d);
        for (int i = 0; i < TO; i++) step(P_STORE, 1'b0, 1'b0, 1'b0, "to_sta_hold", d);
        for (int i = 0; i < 3; i++) step(P_TRAP, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "fault_sticky", d);
        step(P_TRAP, 1'b1, 1'b0, 1'b1, "fault_in_rst", d);
        run_instr(4'b0001, 1'b0, 1, 0, 0, "after_fault", lat);
        chk_int("latency_after_fault", lat, 4);

        // Reset during an operand read aborts without writeback
        instruction = 4'b0011;
        step(P_FETCH, 1'b1, 1'b0, 1'b0, "rl_if", d);
        step(P_DECODE, 1'b1, 1'b0, 1'b0, "rl_dec", d);
        step(P_OPFETCH, 1'b1, 1'b0, 1'b0, "rl_if2", d);
        step(P_MEMRD, 1'b0, 1'b0, 1'b0, "rl_ldm", d);
        step(P_MEMRD, 1'b1, 1'b0, 1'b1, "rl_ldm_rst", d);
        run_instr(4'b1110, 1'b0, 0, 0, 0, "after_ldm_rst", lat);
        chk_int("latency_after_ldm_rst", lat, 4);

        // Random instruction stream with random wait-states
        for (int k = 0; k < 40; k++) begin
            run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), $sformatf("rand%0d", k), lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_ws.md
# mc_ctrl_ws

Multicycle CPU control unit with memory wait-states. It sequences fetch, decode, execute and writeback for the 4-bit-opcode accumulator/register ISA and drives the same datapath control strobes as the current controller. It adds three things:
- a req/ready handshake, so memory may take any number of cycles per access;
- a parametrised bus-timeout that traps into a sticky fault state;
- corrected memory-operand ALU ops (ADA/ANA) with a real execute/writeback path.

It sits between the instruction register and the datapath/memory interface.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles an access may wait for mem_ready. 0 disables the timeout.
- CNT_W, $clog2(MEM_TIMEOUT+1): wait-counter width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- instruction  input  4  IR opcode bits [3:0]
- out_jump_sel  input  1  jump condition from the flag logic
- mem_ready  input  1  memory completes the current read/write in this cycle
- mem_req  output  1  memory access in progress
- bus_fault  output  1  sticky fault flag
- instr_done  output  1  one-cycle pulse in an instruction's final cycle
- ld_PC, ld_IR, ld_DI, ld_ALU, ld_TR, ld_CZN, write_en_rf  output  1 each  register load/write enables
- sel_IR_3_2, sel_DI_4_3, sel_MEM_src_PC, sel_MEM_src_TR, sel_ALU_src_reg1, sel_ALU_src_TR, sel_CZN_src_RF, sel_CZN_src_ALU, sel_PC_src_jump, sel_RF_write_src_ALU, sel_RF_write_src_reg1, sel_RF_write_src_TR_12_5  output  1 each  datapath mux selects
- MEM_read, MEM_write  output  1 each  memory strobes
- cen_PC  output  1  tied 0, kept for datapath compatibility

## Operation
Opcode encoding, checked in this order:
- Full 4-bit: MVR=1100, ADR=1101, ANR=1110, ORR=1111.
- Otherwise instruction[3:1]: LDI=000, LDA=001, STA=010, ADA=011, ANA=100, JMP=101.

States:
- IF: mem_req, MEM_read, sel_MEM_src_PC. ld_IR and ld_PC are asserted only when mem_ready=1. Stays in IF until mem_ready, then goes to DEC.
- DEC: no strobes. Transitions: LDI→LDI, MVR→MVR, ADR/ANR/ORR→RT, all others→IF2.
- LDI: ld_DI, instr_done. Next: IF.
- MVR: sel_RF_write_src_reg1, sel_IR_3_2, write_en_rf, instr_done. Next: IF.
- RT: sel_IR_3_2, sel_ALU_src_reg1, ld_ALU, ld_CZN, sel_CZN_src_ALU. Next: WB_R.
- WB_R: sel_RF_write_src_ALU, write_en_rf, instr_done. Next: IF.
- IF2: same strobes as IF, but loads ld_TR instead of ld_IR (with ld_PC), gated by mem_ready. Stays until mem_ready. Then: JMP→JMP, STA→STA, LDA/ADA/ANA→LDM.
- JMP: ld_PC and sel_PC_src_jump only if out_jump_sel=1. instr_done. Next: IF.
- STA: mem_req, MEM_write, sel_MEM_src_TR, sel_DI_4_3. Strobes are held until mem_ready. instr_done is asserted in the mem_ready cycle. Next: IF.
- LDM: mem_req, MEM_read, sel_MEM_src_TR. ld_TR is asserted only when mem_ready=1. Stays until mem_ready. Then: LDA→LDA, ADA/ANA→ALUM.
- LDA: sel_DI_4_3, sel_RF_write_src_TR_12_5, write_en_rf, ld_CZN, sel_CZN_src_RF, instr_done. Next: IF.
- ALUM: sel_DI_4_3, sel_ALU_src_TR, ld_ALU, ld_CZN, sel_CZN_src_ALU. Next: WB_M.
- WB_M: WB_R strobes plus sel_DI_4_3. Next: IF.
- FAULT: bus_fault=1, all other outputs 0. Exited only by rst.

Wait counter:
- Cleared on entering any memory state (IF, IF2, STA, LDM).
- Increments each cycle that mem_ready=0.
- If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 while mem_ready=0, the next state is FAULT.
- mem_ready=1 in the same cycle always wins over the timeout.
- The counter saturates and never wraps.

## Timing
- Reset: rst high at a rising edge sets state to IF and counter to 0.
- While rst=1, every ld_*, write_en_rf, MEM_write and instr_done is forced to 0.
- Out of reset, the IF strobes (mem_req, MEM_read, sel_MEM_src_PC) are active; bus_fault=0 and all other outputs are 0.
- Reset mid-access or in FAULT aborts immediately. No partial write is completed.
- Outputs are combinational from state. The gating by mem_ready and out_jump_sel is same-cycle (Mealy).
- instruction must be stable from DEC until the end of the instruction. It is sampled in DEC, IF2 and LDM only.
- With mem_ready tied 1, latencies in cycles: LDI 3, MVR 3, ADR/ANR/ORR 4, JMP 4, STA 4, LDA 5, ADA/ANA 6.
- Each wait cycle adds exactly one cycle to the access it occurs in.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum: IF, DEC, LDI, MVR, RT, WB_R, IF2, JMP, STA, LDM, LDA, ALUM, WB_M, FAULT;
  - opcode localparams;
  - a control-word struct for the output bundle.
- Sub-module mem_wait_timer holds the counter and timeout compare. Inputs: clk, rst, start, mem_ready. Output: expired.

## Test plan
- mem_ready=1, instruction=1101 (ADR) → states IF, DEC, RT, WB_R. ld_ALU is asserted in cycle 3, write_en_rf in cycle 4, instr_done in cycle 4.
- mem_ready low for 3 cycles in IF → ld_IR and ld_PC stay 0 for 3 cycles, then pulse once when mem_ready=1. DEC is entered one cycle later.
- instruction=011x (ADA), mem_ready=1 → IF, DEC, IF2, LDM, ALUM, WB_M. sel_ALU_src_TR is asserted in ALUM; write_en_rf and sel_DI_4_3 are asserted in WB_M.
- JMP with out_jump_sel=0, then JMP with out_jump_sel=1 → in the JMP state, ld_PC=0 for the first and ld_PC=1 with sel_PC_src_jump=1 for the second.
- MEM_TIMEOUT=4, STA with mem_ready held 0 → MEM_write is held for 4 cycles, then FAULT with bus_fault=1 and MEM_write=0. bus_fault stays 1 until rst, then the unit returns to IF.
- MEM_TIMEOUT=4, mem_ready=1 on the 4th wait cycle → no fault and normal completion. Also, rst asserted during LDM → next state IF with no write_en_rf.
